outport_tx: RTL and testbench

Transmit side of the CPU's parallel output port. Each `out Ra` instruction writes one 32-bit word from the datapath bus into a small FIFO; the block then delivers each word to an external device using a four-phase strobe/acknowledge handshake. It sits beside the datapath's OutPort register, mirrors the strobe-loaded InPort on the receive side, and keeps the CPU from stalling on a slow device.

---
 rtl/outport_tx.sv | 155 +++++++++++++++
 tb/tb_outport_tx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outport_tx.sv
// Parallel output port transmitter: word FIFO drained by a four-phase strobe/ack handshake.
// Optional acknowledge timeout is enabled by defining OUTPORT_ACK_TIMEOUT_EN.
module outport_tx #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         OutPort,
  input  logic [WIDTH-1:0]             bus_mux_out,
  output logic [WIDTH-1:0]             OutPortOut,
  output logic                         out_strobe,
  input  logic                         out_ack,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("outport_tx: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("outport_tx: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_strobe;
  logic             r_overflow;
  logic             w_push;
  logic             w_pop;
  logic             w_strobe_set;
  logic             w_strobe_clr;

`ifdef OUTPORT_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0]    r_tcnt;
  logic             r_tmo_err;
  logic             w_tmo;
`endif

  assign full        = (r_count == CW'(DEPTH));
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign OutPortOut  = r_out;
  assign out_strobe  = r_strobe;
  assign overflow    = r_overflow;
  // full is judged before any same-cycle pop, so a write while full is always dropped
  assign w_push      = OutPort && !full;

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_strobe_set = 1'b0;
    w_strobe_clr = 1'b0;
`ifdef OUTPORT_ACK_TIMEOUT_EN
    w_tmo        = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // a device still holding ack from before is not offered a new word
        if (!empty && !out_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_strobe_set = 1'b1;
        w_state_nxt  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (out_ack) begin
          w_strobe_clr = 1'b1;
          w_state_nxt  = WAIT_REL;
        end
`ifdef OUTPORT_ACK_TIMEOUT_EN
        else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_strobe_clr = 1'b1;
          w_tmo        = 1'b1;
          w_state_nxt  = IDLE;
        end
`endif
      end
      WAIT_REL: begin
        if (!out_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!clear && w_push) r_mem[r_wptr] <= bus_mux_out;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_strobe   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
        r_out  <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_strobe_set)      r_strobe <= 1'b1;
      else if (w_strobe_clr) r_strobe <= 1'b0;
      if (OutPort && full) r_overflow <= 1'b1;
    end
  end

`ifdef OUTPORT_ACK_TIMEOUT_EN
  // counter sits at zero outside WAIT_ACK, so it is clear on every entry
  always_ff @(posedge clk) begin
    if (clear) begin
      r_tcnt    <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state != WAIT_ACK) r_tcnt <= '0;
      else                     r_tcnt <= r_tcnt + TW'(1);
      if (w_tmo) r_tmo_err <= 1'b1;
    end
  end
  assign timeout_err = r_tmo_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_outport_tx.sv
// Scoreboard bench for outport_tx: queue-level reference model, device emulator with
// programmable acknowledge latency, directed scenarios followed by randomized traffic.
module tb_outport_tx;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              clear = 1'b1;
  logic              OutPort = 1'b0;
  logic [WIDTH-1:0]  bus_mux_out = '0;
  logic              out_ack = 1'b0;
  logic [WIDTH-1:0]  OutPortOut;
  logic              out_strobe;
  logic              full;
  logic              empty;
  logic [2:0]        count;
  logic              overflow;
  logic              timeout_err;

  outport_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clear(clear), .OutPort(OutPort), .bus_mux_out(bus_mux_out),
    .OutPortOut(OutPortOut), .out_strobe(out_strobe), .out_ack(out_ack),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queued words, one transfer slot, expected deliveries
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               m_busy = 0;
  bit               m_acked = 0;
  int               m_t = 0;
  logic [WIDTH-1:0] m_out = '0;
  bit               m_ovf = 0;
  bit               m_tmo = 0;
  bit               m_strobe = 0;
  bit               m_was_full;
  bit               m_do_pop;

  initial begin
    forever begin
      @(posedge clk);
      if (clear) begin
        m_q.delete();
        exp_q.delete();
        m_busy = 0; m_acked = 0; m_t = 0; m_out = '0; m_ovf = 0; m_tmo = 0;
      end else begin
        m_was_full = (m_q.size() == DEPTH);
        m_do_pop   = !m_busy && (m_q.size() > 0) && !out_ack;
        if (m_busy) begin
          if (m_acked) begin
            if (!out_ack) m_busy = 0;
          end else if (m_t >= 1 && out_ack) begin
            m_acked = 1;
          end
`ifdef OUTPORT_ACK_TIMEOUT_EN
          else if (m_t == TIMEOUT) begin
            m_busy = 0;
            m_tmo  = 1;
          end
`endif
          m_t++;
        end
        if (m_do_pop) begin
          m_out   = m_q.pop_front();
          m_busy  = 1;
          m_acked = 0;
          m_t     = 0;
        end
        if (OutPort) begin
          if (!m_was_full) begin
            m_q.push_back(bus_mux_out);
            exp_q.push_back(bus_mux_out);
          end else begin
            m_ovf = 1;
          end
        end
      end
      m_strobe = m_busy && !m_acked && (m_t >= 1);
    end
  end

  // monitor: per-cycle status plus in-order delivery check on each strobe rise
  bit   chk_en = 0;
  logic prev_strobe = 1'b0;
  int   peak = 0;
  int   rises = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("status{full,empty,count,ovf,tmo,strobe}",
            {56'd0, full, empty, count, overflow, timeout_err, out_strobe},
            {56'd0, m_q.size() == DEPTH, m_q.size() == 0, 3'(m_q.size()), m_ovf, m_tmo, m_strobe});
        chk("data_hold", OutPortOut, m_out);
        if (int'(count) > peak) peak = int'(count);
        if (out_strobe && !prev_strobe) begin
          rises++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver: strobe with word %0h, none expected", OutPortOut);
          end else begin
            chk("deliver", OutPortOut, exp_q.pop_front());
          end
        end
      end
      prev_strobe = out_strobe;
    end
  end

  // device emulator
  bit dev_hold = 0;
  bit dev_rand = 0;
  bit force_ack = 0;
  int dev_delay = 0;
  int wcnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (force_ack) begin
        out_ack = 1'b1;
      end else if (out_ack) begin
        if (!out_strobe) out_ack = 1'b0;
      end else if (out_strobe && !dev_hold) begin
        if (wcnt >= dev_delay) begin
          out_ack = 1'b1;
          wcnt = 0;
          if (dev_rand) dev_delay = $urandom_range(0, 3);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic write(input logic [WIDTH-1:0] w);
    OutPort = 1'b1;
    bus_mux_out = w;
    @(negedge clk);
    OutPort = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || m_busy || out_strobe) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_drain_timeout"}, 64'(k >= 400), 64'd0);
  endtask

  initial begin
    idle(2);
    clear = 1'b0;
    chk_en = 1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_strobe", 64'(out_strobe), 64'd0);
    chk("rst_data", OutPortOut, 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // single word, immediate acknowledge
    dev_delay = 0;
    write(32'h55);
    chk("w55_empty_falls", 64'(empty), 64'd0);
    idle(1);
    chk("w55_data", OutPortOut, 64'h55);
    chk("w55_strobe_low", 64'(out_strobe), 64'd0);
    idle(1);
    chk("w55_strobe_high", 64'(out_strobe), 64'd1);
    idle(1);
    chk("w55_strobe_fall", 64'(out_strobe), 64'd0);
    chk("w55_empty", 64'(empty), 64'd1);
    drain("w55");

    // back-to-back writes, slow device
    dev_delay = 5;
    peak = 0;
    rises = 0;
    write(32'h11);
    write(32'h22);
    write(32'h33);
    drain("b2b");
    chk("b2b_peak", 64'(peak), 64'd2);
    chk("b2b_rises", 64'(rises), 64'd3);
    chk("b2b_ovf", 64'(overflow), 64'd0);

    // overflow with device never acknowledging
    dev_hold = 1;
    dev_delay = 0;
    for (int i = 1; i <= DEPTH + 2; i++) write(32'(i));
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    idle(3);
    rises = 0;
    dev_hold = 0;
    drain("ovf");
    chk("ovf_delivered", 64'(rises), 64'd4);
    do_reset();

    // reset during WAIT_ACK with two words queued
    dev_hold = 1;
    write(32'hA1);
    write(32'hA2);
    write(32'hA3);
    idle(3);
    chk("mid_count_before", 64'(count), 64'd2);
    chk("mid_strobe_before", 64'(out_strobe), 64'd1);
    do_reset();
    chk("mid_strobe", 64'(out_strobe), 64'd0);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_data", OutPortOut, 64'd0);
    rises = 0;
    dev_hold = 0;
    idle(10);
    chk("mid_no_strobe", 64'(rises), 64'd0);

    // acknowledge stuck high blocks a new transfer
    force_ack = 1;
    idle(1);
    write(32'h77);
    idle(5);
    chk("stuck_no_strobe", 64'(out_strobe), 64'd0);
    chk("stuck_count", 64'(count), 64'd1);
    force_ack = 0;
    drain("stuck");

`ifdef OUTPORT_ACK_TIMEOUT_EN
    do_reset();
    dev_hold = 1;
    write(32'hAA);
    write(32'hBB);
    begin
      int k = 0;
      while (!timeout_err && k < 60) begin
        @(negedge clk);
        k++;
      end
      chk("tmo_flag", 64'(timeout_err), 64'd1);
    end
    chk("tmo_strobe_low", 64'(out_strobe), 64'd0);
    dev_hold = 0;
    drain("tmo");
    chk("tmo_sticky", 64'(timeout_err), 64'd1);
`endif

    // randomized traffic with random device latency and occasional reset
    do_reset();
    dev_rand = 1;
    for (int i = 0; i < 600; i++) begin
      OutPort = ($urandom_range(0, 2) == 0);
      bus_mux_out = $urandom;
      clear = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    OutPort = 1'b0;
    clear = 1'b0;
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
